// File: rtl/timer_peripheral.sv
// timer_peripheral
//
// Memory-mapped 32-bit timer for a small CPU data bus.
//   0x40000000  TH    reload value loaded into TL on overflow
//   0x40000004  TL    the counter itself
//   0x40000008  TCON  [0] enable, [1] interrupt enable,
//                     [2] interrupt pending, [3] one-shot
//   0x40000014  SYSTICK read-only free-running cycle counter, only when the
//               build defines TIMER_SYSTICK_EN
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   reset       synchronous active-high reset
//   MemRead     bus read strobe
//   MemWrite    bus write strobe
//   address     byte address of the access (must be word aligned to match)
//   write_data  store data
//   read_data   load data, combinational, zero unless a read hits this block
//   hit         address decodes to one of this block's registers
//   IRQ         interrupt request, interrupt enable AND pending
//
// Optional feature macro: TIMER_SYSTICK_EN

module timer_peripheral (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        IRQ
);

    localparam logic [31:0] TH_ADDR   = 32'h4000_0000;
    localparam logic [31:0] TL_ADDR   = 32'h4000_0004;
    localparam logic [31:0] TCON_ADDR = 32'h4000_0008;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] th;
    logic [31:0] tl;
    logic        int_enable;
    logic        pending;
    logic        one_shot;

    logic        sel_th;
    logic        sel_tl;
    logic        sel_tcon;
    logic        sel_systick;
    logic        write_th;
    logic        write_tl;
    logic        write_tcon;
    logic        overflow;
    logic [31:0] tcon_value;

    // Exact 32-bit compares also reject misaligned addresses.
    assign sel_th   = (address == TH_ADDR);
    assign sel_tl   = (address == TL_ADDR);
    assign sel_tcon = (address == TCON_ADDR);

`ifdef TIMER_SYSTICK_EN
    localparam logic [31:0] SYSTICK_ADDR = 32'h4000_0014;
    logic [31:0] systick;

    assign sel_systick = (address == SYSTICK_ADDR);

    // Free-running cycle counter; never written by the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            systick <= 32'h0;
        end else begin
            systick <= systick + 32'h1;
        end
    end
`else
    assign sel_systick = 1'b0;
`endif

    // The block is invisible to the bus while reset is held.
    assign hit = !reset && (sel_th || sel_tl || sel_tcon || sel_systick);

    assign write_th   = MemWrite && hit && sel_th;
    assign write_tl   = MemWrite && hit && sel_tl;
    assign write_tcon = MemWrite && hit && sel_tcon;

    // A TL store in the same cycle pre-empts the wrap, so no reload and no
    // interrupt come from a counter value that software is replacing.
    assign overflow = (state == RUN) && (tl == 32'hFFFF_FFFF) && !write_tl;

    assign tcon_value = {28'h0, one_shot, pending, int_enable, state == RUN};

    assign IRQ = int_enable && pending;

    always_comb begin
        read_data = 32'h0;
        if (MemRead && hit) begin
            if (sel_th) begin
                read_data = th;
            end else if (sel_tl) begin
                read_data = tl;
            end else if (sel_tcon) begin
                read_data = tcon_value;
            end
`ifdef TIMER_SYSTICK_EN
            else if (sel_systick) begin
                read_data = systick;
            end
`endif
        end
    end

    // Timer FSM and its registers. The enable bit of TCON is the state
    // itself, so IDLE/RUN and TCON[0] can never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            th         <= 32'h0;
            tl         <= 32'h0;
            int_enable <= 1'b0;
            pending    <= 1'b0;
            one_shot   <= 1'b0;
        end else begin
            if (write_th) begin
                th <= write_data;
            end

            if (write_tl) begin
                tl <= write_data;
            end else if (overflow) begin
                tl <= th;
            end else if (state == RUN) begin
                tl <= tl + 32'h1;
            end

            // A TCON store overrides the overflow side effects on enable,
            // but a pending interrupt raised in the same cycle still lands.
            if (write_tcon) begin
                state      <= write_data[0] ? RUN : IDLE;
                int_enable <= write_data[1];
                pending    <= write_data[2] || (overflow && int_enable);
                one_shot   <= write_data[3];
            end else if (overflow) begin
                if (int_enable) begin
                    pending <= 1'b1;
                end
                if (one_shot) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule
